// File: rtl/fft_reorder_64_pkg.sv
// Shared constants, payload type and bit-reverse helper for the FFT output reorder unit.
package fft_reorder_64_pkg;

  localparam int unsigned DATA_W = 22;
  localparam int unsigned LOG2N  = 6;
  localparam int unsigned N      = 2 ** LOG2N;
  localparam int unsigned ADDR_W = LOG2N + 1;

  localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] FIRST_IDX = LOG2N'(0);

  // One registered output beat toward the downstream consumer.
  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [DATA_W-1:0] data;
  } outBeat_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_64_ram.sv
// Two-bank frame store: synchronous write port, asynchronous read port, address {bank, idx}.
module fft_reorder_64_ram
  import fft_reorder_64_pkg::*;
(
  input  logic              iClk,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData_c
);

  logic [DATA_W-1:0] mem [2*N];

  // Contents are deliberately not reset; bank_full gates every read.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem[iWrAddr] <= iWrData;
    end
  end

  assign oRdData_c = mem[iRdAddr];

endmodule

// File: rtl/fft_reorder_64.sv
// Collects bit-reversed 64-point frames into ping-pong banks and replays them in natural bin order.
module fft_reorder_64
  import fft_reorder_64_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  output logic              oInReady,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oSof,
  output logic              oEof,
  input  logic              iReady
);

  logic             wsel;
  logic             rsel;
  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic [1:0]       bankFull;
  logic [1:0]       bankFullNext;
  logic             wrEn;
  logic             load;
  logic             wrLast;
  logic             rdLast;
  logic [DATA_W-1:0] rdData_c;
  outBeat_t         beat;

  fft_reorder_64_ram uRam (
    .iClk      (iClk),
    .iWe       (wrEn),
    .iWrAddr   ({wsel, bitrev(wcnt)}),
    .iWrData   (iData),
    .iRdAddr   ({rsel, rcnt}),
    .oRdData_c (rdData_c)
  );

  // Handshake decode; set and clear of bank_full never target the same bank.
  always_comb begin
    oInReady     = !bankFull[wsel];
    wrEn         = iValid & oInReady;
    load         = bankFull[rsel] & (!oValid | iReady);
    wrLast       = wrEn && (wcnt == LAST_IDX);
    rdLast       = load && (rcnt == LAST_IDX);
    bankFullNext = bankFull;
    if (wrLast) bankFullNext[wsel] = 1'b1;
    if (rdLast) bankFullNext[rsel] = 1'b0;
  end

  // Bank bookkeeping and frame counters.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      wcnt     <= '0;
      rcnt     <= '0;
      bankFull <= 2'b00;
    end else begin
      bankFull <= bankFullNext;
      if (wrEn) begin
        wcnt <= wcnt + LOG2N'(1);
        if (wrLast) wsel <= ~wsel;
      end
      if (load) begin
        rcnt <= rcnt + LOG2N'(1);
        if (rdLast) rsel <= ~rsel;
      end
    end
  end

  // Show-ahead output register; holds while the consumer stalls.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid <= 1'b0;
      beat   <= '0;
    end else if (load) begin
      oValid    <= 1'b1;
      beat.data <= rdData_c;
      beat.sof  <= (rcnt == FIRST_IDX);
      beat.eof  <= (rcnt == LAST_IDX);
    end else if (iReady) begin
      oValid   <= 1'b0;
      beat.sof <= 1'b0;
      beat.eof <= 1'b0;
    end
  end

  assign oData = beat.data;
  assign oSof  = beat.sof;
  assign oEof  = beat.eof;

endmodule

// File: tb/tb_fft_reorder_64.sv
// Scoreboard bench for fft_reorder_64: bit-reversed frames in, natural-order frames out.
module tb_fft_reorder_64;

  typedef struct {
    logic [21:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iValid = 1'b0;
  logic [21:0] iData = '0;
  logic        oInReady;
  logic        oValid;
  logic [21:0] oData;
  logic        oSof;
  logic        oEof;
  logic        iReady = 1'b1;

  int   nChecks = 0;
  int   nFails  = 0;
  int   readyMode = 1;   // 0: stall, 1: always ready, 2: random
  int   inRdyDrops = 0;
  int   kIn = 0;
  logic [21:0] frameBuf [64];
  exp_t q[$];

  fft_reorder_64 dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iValid   (iValid),
    .iData    (iData),
    .oInReady (oInReady),
    .oValid   (oValid),
    .oData    (oData),
    .oSof     (oSof),
    .oEof     (oEof),
    .iReady   (iReady)
  );

  always #5 iClk = ~iClk;

  function automatic int bitRev6(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) r = r | (((k >> i) & 1) << (5 - i));
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge iClk) begin
    #1;
    case (readyMode)
      0:       iReady = 1'b0;
      1:       iReady = 1'b1;
      default: iReady = 1'($urandom_range(1));
    endcase
  end

  // Handshakes are judged mid-cycle; the matching transfer happens at the next rising edge.
  always @(negedge iClk) begin
    if (!iRst_n) begin
      q.delete();
      kIn = 0;
    end else begin
      if (oValid && iReady) begin
        if (q.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL spurious: got output %0h expected none", oData);
        end else begin
          exp_t e;
          e = q.pop_front();
          checkVal("data", 32'(oData), 32'(e.d));
          checkVal("sof", 32'(oSof), 32'(e.sof));
          checkVal("eof", 32'(oEof), 32'(e.eof));
        end
      end
      if (iValid && oInReady) begin
        frameBuf[kIn] = iData;
        kIn++;
        if (kIn == 64) begin
          for (int j = 0; j < 64; j++) begin
            exp_t e;
            e.d   = frameBuf[bitRev6(j)];
            e.sof = (j == 0);
            e.eof = (j == 63);
            q.push_back(e);
          end
          kIn = 0;
        end
      end
      if (!oInReady) inRdyDrops++;
    end
  end

  task automatic sendFrame(input int base, input int pct, input int nSamp, input bit rnd);
    int  cyc;
    bit  acc;
    cyc = 0;
    for (int k = 0; k < nSamp; k++) begin
      iData = rnd ? 22'($urandom) : 22'(base + bitRev6(k));
      acc = 1'b0;
      while (!acc) begin
        iValid = ($urandom_range(99) < 32'(pct));
        @(negedge iClk);
        acc = iValid && oInReady;
        @(posedge iClk);
        #1;
        cyc++;
        if (cyc > 4000) begin
          nChecks++;
          nFails++;
          $display("FAIL sendTimeout: got %0d accepts expected %0d", k, nSamp);
          iValid = 1'b0;
          return;
        end
      end
    end
    iValid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int c;
    c = 0;
    while (q.size() != 0 && c < budget) begin
      @(posedge iClk);
      #1;
      c++;
    end
    checkVal("drainEmpty", 32'(q.size()), 32'(0));
    checkVal("idleValid", 32'(oValid), 32'(0));
  endtask

  task automatic doReset();
    iValid = 1'b0;
    iRst_n = 1'b0;
    #1;
    checkVal("rstValid", 32'(oValid), 32'(0));
    checkVal("rstData", 32'(oData), 32'(0));
    checkVal("rstSof", 32'(oSof), 32'(0));
    checkVal("rstEof", 32'(oEof), 32'(0));
    repeat (2) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    checkVal("rstInReady", 32'(oInReady), 32'(1));
  endtask

  initial begin
    // Frame in, natural order out, with first-output latency.
    readyMode = 1;
    doReset();
    sendFrame(0, 100, 64, 1'b0);
    checkVal("latNotYet", 32'(oValid), 32'(0));
    @(posedge iClk);
    #1;
    checkVal("latValid", 32'(oValid), 32'(1));
    checkVal("latData", 32'(oData), 32'(0));
    checkVal("latSof", 32'(oSof), 32'(1));
    waitDrain(200);

    // Back-to-back frames with no input stall.
    inRdyDrops = 0;
    for (int f = 0; f < 3; f++) sendFrame(f * 64, 100, 64, 1'b0);
    checkVal("inRdyHeld", 32'(inRdyDrops), 32'(0));
    waitDrain(300);

    // Full stall, both banks fill, then release while frame 3 is pending.
    doReset();
    readyMode = 0;
    @(posedge iClk);
    #1;
    sendFrame(0, 100, 64, 1'b0);
    sendFrame(64, 100, 64, 1'b0);
    checkVal("bothFullRdy", 32'(oInReady), 32'(0));
    repeat (4) begin
      checkVal("holdValid", 32'(oValid), 32'(1));
      checkVal("holdData", 32'(oData), 32'(0));
      checkVal("holdSof", 32'(oSof), 32'(1));
      @(posedge iClk);
      #1;
    end
    fork
      sendFrame(128, 100, 64, 1'b0);
      begin
        repeat (6) @(posedge iClk);
        #1;
        readyMode = 1;
      end
    join
    waitDrain(400);

    // Random valid and ready.
    readyMode = 2;
    for (int f = 0; f < 10; f++) sendFrame(0, 50, 64, 1'b1);
    waitDrain(3000);

    // Reset mid-read with a partial frame in flight.
    readyMode = 1;
    @(posedge iClk);
    #1;
    sendFrame(0, 100, 64, 1'b0);
    sendFrame(64, 100, 30, 1'b0);
    checkVal("midReadValid", 32'(oValid), 32'(1));
    doReset();
    sendFrame(256, 100, 64, 1'b0);
    @(posedge iClk);
    #1;
    checkVal("postRstData", 32'(oData), 32'(256));
    checkVal("postRstSof", 32'(oSof), 32'(1));
    waitDrain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
